sseg_capture: RTL and testbench

Receive-side monitor for the multiplexed seven-segment display bus. It watches the active-low `an`/`sseg` lines driven by the display decoder, waits for each digit to dwell stably, and maps each segment pattern back to a hex nibble. It assembles the four digits into a 16-bit word and pulses `valid` once per complete scan frame. It is used on-board as a loopback checker and in benches as the display-side scoreboard.

---
 rtl/sseg_capture.sv | 198 +++++++++++++++++++
 tb/tb_sseg_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// sseg_capture: receive-side monitor for a multiplexed, active-low seven-segment bus.
// Waits for each anode code to dwell stably, then decodes the segment pattern back
// to a hex nibble. It assembles four digits into a 16-bit word and pulses valid
// once per complete scan frame.
// Optional feature: define SSEG_CAPTURE_DP_EN to add decimal-point capture
// (dp input, dp_out output).
module sseg_capture #(
   parameter int unsigned STABLE = 4   // dwell length in registered cycles, 2..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  sseg,
`ifdef SSEG_CAPTURE_DP_EN
   input  logic        dp,
   output logic [3:0]  dp_out,
`endif
   output logic [15:0] value,
   output logic        valid,
   output logic        frame_err,
   output logic [3:0]  seen
);

   localparam logic [7:0] STABLE_C  = 8'(STABLE);
   localparam logic [7:0] STABLE_M1 = 8'(STABLE - 1);

   // Input stage
   logic [3:0]  r_an_q;
   logic [6:0]  r_sseg_q;

   // Dwell tracking
   logic [7:0]  r_cnt;

   // Frame assembly
   logic [15:0] r_slots;
   logic [3:0]  r_seen;
   logic        r_bad;

   // Registered outputs
   logic [15:0] r_value;
   logic        r_valid;
   logic        r_frame_err;

   // Combinational helpers
   logic        w_legal;
   logic [1:0]  w_idx;
   logic [3:0]  w_sel;
   logic        w_chg;
   logic        w_sample;
   logic        w_full;
   logic [3:0]  w_nib;
   logic        w_inv;
   logic [3:0]  w_seen_base;
   logic        w_bad_base;

`ifdef SSEG_CAPTURE_DP_EN
   logic        r_dp_q;
   logic [3:0]  r_dp_slot;
   logic [3:0]  r_dp_out;
`endif

   // Register the bus pins once; reset to the blanked/idle pattern
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an_q   <= 4'hF;
         r_sseg_q <= 7'h7F;
`ifdef SSEG_CAPTURE_DP_EN
         r_dp_q   <= 1'b1;
`endif
      end else begin
         r_an_q   <= an;
         r_sseg_q <= sseg;
`ifdef SSEG_CAPTURE_DP_EN
         r_dp_q   <= dp;
`endif
      end
   end

   // Anode legality: exactly one active-low enable, and which digit it selects
   always_comb begin
      w_legal = 1'b1;
      w_idx   = 2'd0;
      case (r_an_q)
         4'b1110: w_idx = 2'd0;
         4'b1101: w_idx = 2'd1;
         4'b1011: w_idx = 2'd2;
         4'b0111: w_idx = 2'd3;
         default: begin
            w_legal = 1'b0;
            w_idx   = 2'd0;
         end
      endcase
   end

   assign w_sel = 4'b0001 << w_idx;

   // A new code is detected on the edge where it enters r_an_q, so the dwell count
   // starts at zero in the first cycle the registered copy holds the new code.
   assign w_chg    = (an != r_an_q);
   assign w_sample = w_legal && !w_chg && (r_cnt == STABLE_M1);
   assign w_full   = (r_seen == 4'hF);

   // Dwell counter: cleared on illegal/changing anode, saturates at STABLE so a
   // single dwell samples at most once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (!w_legal || w_chg) begin
         r_cnt <= 8'd0;
      end else if (r_cnt != STABLE_C) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Segment decode (gfedcba, active-low) back to a hex nibble
   always_comb begin
      w_inv = 1'b0;
      w_nib = 4'h0;
      case (r_sseg_q)
         7'h40: w_nib = 4'h0;
         7'h79: w_nib = 4'h1;
         7'h24: w_nib = 4'h2;
         7'h30: w_nib = 4'h3;
         7'h19: w_nib = 4'h4;
         7'h12: w_nib = 4'h5;
         7'h02: w_nib = 4'h6;
         7'h78: w_nib = 4'h7;
         7'h00: w_nib = 4'h8;
         7'h10: w_nib = 4'h9;
         7'h08: w_nib = 4'hA;
         7'h03: w_nib = 4'hB;
         7'h46: w_nib = 4'hC;
         7'h21: w_nib = 4'hD;
         7'h06: w_nib = 4'hE;
         7'h0E: w_nib = 4'hF;
         default: begin
            w_nib = 4'h0;
            w_inv = 1'b1;
         end
      endcase
   end

   // Frame bookkeeping clears on the completion cycle; a sample in that same cycle
   // (not reachable for STABLE >= 2) would still be kept for the next frame.
   assign w_seen_base = w_full ? 4'h0 : r_seen;
   assign w_bad_base  = w_full ? 1'b0 : r_bad;

   // Slot writes and per-frame seen/bad tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slots <= 16'h0000;
         r_seen  <= 4'h0;
         r_bad   <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
         r_dp_slot <= 4'h0;
`endif
      end else begin
         r_seen <= w_seen_base | (w_sample ? w_sel : 4'h0);
         r_bad  <= w_bad_base | (w_sample & w_inv);
         if (w_sample) begin
            r_slots[4*w_idx +: 4] <= w_nib;
`ifdef SSEG_CAPTURE_DP_EN
            r_dp_slot[w_idx] <= ~r_dp_q;
`endif
         end
      end
   end

   // Publish the frame one cycle after the last missing digit is captured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value     <= 16'h0000;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
         r_dp_out    <= 4'h0;
`endif
      end else begin
         r_valid <= w_full;
         if (w_full) begin
            r_value     <= r_slots;
            r_frame_err <= r_bad;
`ifdef SSEG_CAPTURE_DP_EN
            r_dp_out    <= r_dp_slot;
`endif
         end
      end
   end

   assign value     = r_value;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign seen      = r_seen;
`ifdef SSEG_CAPTURE_DP_EN
   assign dp_out    = r_dp_out;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
// Directed self-checking bench for sseg_capture (STABLE = 4).
// Define SSEG_CAPTURE_DP_EN for both files to include the decimal-point case.
module tb_sseg_capture;

   localparam int unsigned STABLE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic        dp_pin;
   logic [15:0] value;
   logic        valid;
   logic        frame_err;
   logic [3:0]  seen;
`ifdef SSEG_CAPTURE_DP_EN
   logic [3:0]  dp_out;
`endif

   sseg_capture #(.STABLE(STABLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .an        (an),
      .sseg      (sseg),
`ifdef SSEG_CAPTURE_DP_EN
      .dp        (dp_pin),
      .dp_out    (dp_out),
`endif
      .value     (value),
      .valid     (valid),
      .frame_err (frame_err),
      .seen      (seen)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          valid_cnt = 0;
   int          back_to_back = 0;
   int unsigned last_valid_cyc = 0;
   int unsigned frame_t4 = 0;
   logic [15:0] last_value = 16'h0;
   logic        last_err = 1'b0;
   logic [3:0]  last_dp = 4'h0;
   bit          prev_valid = 1'b0;
   int          vc0;

   // Observe valid pulses away from the active edge
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         last_value     = value;
         last_err       = frame_err;
`ifdef SSEG_CAPTURE_DP_EN
         last_dp        = dp_out;
`endif
         if (prev_valid) back_to_back++;
      end
      prev_valid = (valid === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one anode/segment code for n clocks; returns at posedge + 1
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      an     = a;
      sseg   = s;
      dp_pin = d;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full scan, digits 0..3, 8 clocks each, then blank
   task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input logic [3:0] dpm);
      hold(4'hE, s0, dpm[0], 8);
      hold(4'hD, s1, dpm[1], 8);
      hold(4'hB, s2, dpm[2], 8);
      frame_t4 = cyc;
      hold(4'h7, s3, dpm[3], 8);
      hold(4'hF, 7'h7F, 1'b1, 4);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      an     = 4'hF;
      sseg   = 7'h7F;
      dp_pin = 1'b1;
      rst    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_value", 32'(value), 32'h0);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_err",   32'(frame_err), 32'h0);
      check("reset_seen",  32'(seen), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic frame 0123 with latency measurement
      vc0 = valid_cnt;
      frame(7'h30, 7'h24, 7'h79, 7'h40, 4'hF);
      check("basic_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
      check("basic_value", 32'(last_value), 32'h0123);
      check("basic_err", 32'(last_err), 32'h0);
      check("basic_latency", last_valid_cyc - frame_t4, STABLE + 2);
      check("basic_seen_clr", 32'(seen), 32'h0);

      // Remaining decode table entries
      frame(7'h19, 7'h12, 7'h02, 7'h78, 4'hF);
      check("dec_7654", 32'(last_value), 32'h7654);
      frame(7'h00, 7'h10, 7'h08, 7'h03, 4'hF);
      check("dec_ba98", 32'(last_value), 32'hBA98);
      frame(7'h46, 7'h21, 7'h06, 7'h0E, 4'hF);
      check("dec_fedc", 32'(last_value), 32'hFEDC);
      check("dec_fedc_err", 32'(last_err), 32'h0);

      // Unrecognised pattern on digit 1
      vc0 = valid_cnt;
      frame(7'h0E, 7'h7F, 7'h46, 7'h21, 4'hF);
      check("inv_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
      check("inv_value", 32'(last_value), 32'hDC0F);
      check("inv_err", 32'(last_err), 32'h1);
      frame(7'h30, 7'h24, 7'h79, 7'h40, 4'hF);
      check("inv_err_clears", 32'(last_err), 32'h0);

      // Glitch inside digit 0's dwell: restart, single capture
      vc0 = valid_cnt;
      hold(4'hE, 7'h19, 1'b1, 3);
      hold(4'hD, 7'h19, 1'b1, 1);
      hold(4'hE, 7'h19, 1'b1, 8);
      check("glitch_seen", 32'(seen), 32'h1);
      hold(4'hD, 7'h12, 1'b1, 8);
      hold(4'hB, 7'h02, 1'b1, 8);
      hold(4'h7, 7'h78, 1'b1, 8);
      hold(4'hF, 7'h7F, 1'b1, 4);
      check("glitch_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
      check("glitch_value", 32'(last_value), 32'h7654);

      // Short dwell on digit 2 in the first pass
      vc0 = valid_cnt;
      hold(4'hE, 7'h30, 1'b1, 8);
      hold(4'hD, 7'h24, 1'b1, 8);
      hold(4'hB, 7'h79, 1'b1, 3);
      hold(4'h7, 7'h40, 1'b1, 8);
      hold(4'hF, 7'h7F, 1'b1, 4);
      check("short_no_valid", 32'(valid_cnt - vc0), 32'd0);
      check("short_seen", 32'(seen), 32'hB);
      frame(7'h30, 7'h24, 7'h79, 7'h40, 4'hF);
      check("short_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
      check("short_value", 32'(last_value), 32'h0123);
      check("short_seen_left", 32'(seen), 32'h8);

      // Illegal anode codes
      do_reset();
      vc0 = valid_cnt;
      hold(4'b1100, 7'h30, 1'b1, 20);
      check("illegal_multi_cnt", 32'(dut.r_cnt), 32'h0);
      check("illegal_multi_seen", 32'(seen), 32'h0);
      hold(4'hF, 7'h30, 1'b1, 20);
      check("illegal_blank_cnt", 32'(dut.r_cnt), 32'h0);
      check("illegal_blank_seen", 32'(seen), 32'h0);
      check("illegal_no_valid", 32'(valid_cnt - vc0), 32'd0);

      // Asynchronous reset mid-frame
      hold(4'hE, 7'h19, 1'b1, 8);
      hold(4'hD, 7'h12, 1'b1, 8);
      check("midrst_seen_before", 32'(seen), 32'h3);
      vc0 = valid_cnt;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_seen_now", 32'(seen), 32'h0);
      check("midrst_value_now", 32'(value), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold(4'hF, 7'h7F, 1'b1, 4);
      check("midrst_no_valid", 32'(valid_cnt - vc0), 32'd0);
      frame(7'h00, 7'h10, 7'h08, 7'h03, 4'hF);
      check("midrst_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
      check("midrst_value", 32'(last_value), 32'hBA98);

`ifdef SSEG_CAPTURE_DP_EN
      // Decimal point lit on digit 2 only
      frame(7'h30, 7'h24, 7'h79, 7'h40, 4'b1011);
      check("dp_out", 32'(last_dp), 32'h4);
`endif

      check("valid_back_to_back", 32'(back_to_back), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
